// File: rtl/l1_trig_multiplier.sv
// L1 trigger multiplier: expands each LV1 command into a burst of TrigCnt trigger
// pulses, queues LV1s that arrive mid-burst, and keeps all state in voted TMR copies.
module l1_trig_multiplier #(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned PEND_MAX = 4,
  parameter int unsigned DROP_W   = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Lv1_In,
  input  logic              ClearIn,
  input  logic [CNT_W-1:0]  TrigCnt,
  output logic              L1_Trig_Out,
  output logic              ClearTrigId,
  output logic              Busy,
  output logic [3:0]        Pending,
  output logic              Overflow,
  output logic [DROP_W-1:0] DropCnt,
  output logic              Error
);

  localparam int unsigned REM_W  = CNT_W + 1;
  localparam int unsigned PEND_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // One hardened copy of all protected state; remain sits in the LSBs.
  typedef struct packed {
    state_e              state;
    logic                overflow;
    logic [DROP_W-1:0]   drop;
    logic [PEND_W-1:0]   pend;
    logic [REM_W-1:0]    remain;
  } tmr_t;

  tmr_t             tmr0_q, tmr1_q, tmr2_q;
  tmr_t             voted;
  tmr_t             tmr_d;
  logic             clear_q, clear_d;
  logic [2:0]       err_q;
  logic             mismatch;
  logic             req, consume, accept, drop;
  logic [REM_W-1:0] load_cnt;

  // Bitwise 2-of-3 vote; every copy reloads from the voted value, so a single upset heals in one clock.
  assign voted    = tmr_t'((tmr0_q & tmr1_q) | (tmr0_q & tmr2_q) | (tmr1_q & tmr2_q));
  assign mismatch = (tmr0_q != tmr1_q) || (tmr1_q != tmr2_q);

  // A TrigCnt of zero encodes the full 2**CNT_W pulse burst.
  assign load_cnt = (TrigCnt == '0) ? {1'b1, CNT_W'(0)} : {1'b0, TrigCnt};

  always_comb begin
    tmr_d   = voted;
    clear_d = 1'b0;
    consume = 1'b0;
    accept  = 1'b0;
    drop    = 1'b0;
    req     = Lv1_In | (voted.pend != '0);

    if (ClearIn) begin
      tmr_d   = tmr_t'('0);
      clear_d = 1'b1;
    end else begin
      case (voted.state)
        IDLE: begin
          if (req) begin
            tmr_d.state  = BURST;
            tmr_d.remain = load_cnt;
            consume      = 1'b1;
          end
        end
        BURST: begin
          if (voted.remain == REM_W'(1)) begin
            if (req) begin
              tmr_d.remain = load_cnt;
              consume      = 1'b1;
            end else begin
              tmr_d.state  = IDLE;
              tmr_d.remain = '0;
            end
          end else begin
            tmr_d.remain = voted.remain - REM_W'(1);
          end
        end
        default: tmr_d.state = IDLE;
      endcase

      // A full queue only refuses the LV1 when nothing leaves it this cycle.
      drop   = Lv1_In && (voted.pend == PEND_W'(PEND_MAX)) && !consume;
      accept = Lv1_In && !drop;
      tmr_d.pend = voted.pend + PEND_W'(accept) - PEND_W'(consume);

      if (drop) begin
        tmr_d.overflow = 1'b1;
        if (voted.drop != '1) begin
          tmr_d.drop = voted.drop + DROP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      tmr0_q  <= tmr_t'('0);
      tmr1_q  <= tmr_t'('0);
      tmr2_q  <= tmr_t'('0);
      clear_q <= 1'b0;
      err_q   <= '0;
    end else begin
      tmr0_q  <= tmr_d;
      tmr1_q  <= tmr_d;
      tmr2_q  <= tmr_d;
      clear_q <= clear_d;
      err_q   <= {3{mismatch}};
    end
  end

  assign Busy        = (voted.state == BURST);
  assign L1_Trig_Out = (voted.state == BURST);
  assign Pending     = voted.pend;
  assign Overflow    = voted.overflow;
  assign DropCnt     = voted.drop;
  assign ClearTrigId = clear_q;
  assign Error       = (err_q[0] & err_q[1]) | (err_q[0] & err_q[2]) | (err_q[1] & err_q[2]);

endmodule

// File: tb/tb_l1_trig_multiplier.sv
// Directed bench for l1_trig_multiplier: scenario table of burst/queue cases plus
// hand sequences for ClearIn, asynchronous reset mid-burst and a TMR copy upset.
module tb_l1_trig_multiplier;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DROP_W = 8;

  logic              Clk;
  logic              Reset;
  logic              Lv1_In;
  logic              ClearIn;
  logic [CNT_W-1:0]  TrigCnt;
  logic              L1_Trig_Out;
  logic              ClearTrigId;
  logic              Busy;
  logic [3:0]        Pending;
  logic              Overflow;
  logic [DROP_W-1:0] DropCnt;
  logic              Error;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] trig;       // TrigCnt while the first LV1 is sampled
    logic [3:0] trig2;      // TrigCnt for every later cycle
    int         n_lv1;
    int         sp;         // LV1 spacing in cycles
    int         exp_pulses;
    int         exp_peak;
    int         exp_drop;
    int         exp_ovf;
  } scen_t;

  scen_t scen [8];

  l1_trig_multiplier #(
    .CNT_W    (CNT_W),
    .PEND_MAX (4),
    .DROP_W   (DROP_W)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Lv1_In      (Lv1_In),
    .ClearIn     (ClearIn),
    .TrigCnt     (TrigCnt),
    .L1_Trig_Out (L1_Trig_Out),
    .ClearTrigId (ClearTrigId),
    .Busy        (Busy),
    .Pending     (Pending),
    .Overflow    (Overflow),
    .DropCnt     (DropCnt),
    .Error       (Error)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic run_scen(input int k);
    int pulses   = 0;
    int first    = -1;
    int last     = -1;
    int busy_cnt = 0;
    int peak     = 0;
    bit done     = 1'b0;
    ClearIn = 1'b1;
    tick();
    ClearIn = 1'b0;
    check($sformatf("s%0d_clrid_on", k), int'(ClearTrigId), 1);
    tick();
    check($sformatf("s%0d_clrid_off", k), int'(ClearTrigId), 0);
    for (int c = 0; c < 200 && !done; c++) begin
      Lv1_In  = (c < scen[k].n_lv1 * scen[k].sp) && (c % scen[k].sp == 0);
      TrigCnt = (c == 0) ? scen[k].trig : scen[k].trig2;
      tick();
      if (L1_Trig_Out) begin
        if (first < 0) first = c + 1;
        last = c + 1;
        pulses++;
      end
      if (Busy) busy_cnt++;
      if (int'(Pending) > peak) peak = int'(Pending);
      if ((c + 1 >= scen[k].n_lv1 * scen[k].sp) && !Busy) done = 1'b1;
    end
    Lv1_In = 1'b0;
    check($sformatf("s%0d_done_in_budget", k), int'(done), 1);
    check($sformatf("s%0d_pulses", k), pulses, scen[k].exp_pulses);
    check($sformatf("s%0d_first_latency", k), first, 1);
    check($sformatf("s%0d_contiguous_span", k), last - first + 1, pulses);
    check($sformatf("s%0d_busy_cycles", k), busy_cnt, scen[k].exp_pulses);
    check($sformatf("s%0d_peak_pending", k), peak, scen[k].exp_peak);
    check($sformatf("s%0d_final_pending", k), int'(Pending), 0);
    check($sformatf("s%0d_dropcnt", k), int'(DropCnt), scen[k].exp_drop);
    check($sformatf("s%0d_overflow", k), int'(Overflow), scen[k].exp_ovf);
  endtask

  initial begin
    int pulses;
    int clr_seen;

    //            trig  trig2  n  sp  pulses peak drop ovf
    scen[0] = '{4'd3, 4'd3, 1, 1,  3, 0, 0, 0};
    scen[1] = '{4'd0, 4'd0, 1, 1, 16, 0, 0, 0};
    scen[2] = '{4'd1, 4'd1, 5, 1,  5, 0, 0, 0};
    scen[3] = '{4'd4, 4'd4, 3, 1, 12, 2, 0, 0};
    scen[4] = '{4'd8, 4'd8, 7, 1, 40, 4, 2, 1};
    scen[5] = '{4'd2, 4'd2, 4, 2,  8, 0, 0, 0};
    scen[6] = '{4'd3, 4'd7, 1, 1,  3, 0, 0, 0};
    scen[7] = '{4'd4, 4'd2, 3, 1,  8, 2, 0, 0};

    Reset   = 1'b0;
    Lv1_In  = 1'b0;
    ClearIn = 1'b0;
    TrigCnt = '0;
    @(negedge Clk);
    check("rst_l1", int'(L1_Trig_Out), 0);
    check("rst_clrid", int'(ClearTrigId), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_pending", int'(Pending), 0);
    check("rst_overflow", int'(Overflow), 0);
    check("rst_dropcnt", int'(DropCnt), 0);
    check("rst_error", int'(Error), 0);
    Reset = 1'b1;
    tick();

    for (int k = 0; k < 8; k++) run_scen(k);

    // ClearIn mid-burst with a full queue and a simultaneous LV1.
    TrigCnt = 4'd8;
    for (int c = 0; c < 6; c++) begin
      Lv1_In = 1'b1;
      tick();
    end
    check("clr_pre_pending", int'(Pending), 4);
    check("clr_pre_dropcnt", int'(DropCnt), 1);
    check("clr_pre_overflow", int'(Overflow), 1);
    ClearIn = 1'b1;
    tick();
    ClearIn = 1'b0;
    Lv1_In  = 1'b0;
    check("clr_clrid_on", int'(ClearTrigId), 1);
    check("clr_l1_off", int'(L1_Trig_Out), 0);
    check("clr_busy_off", int'(Busy), 0);
    check("clr_pending", int'(Pending), 0);
    check("clr_dropcnt", int'(DropCnt), 0);
    check("clr_overflow", int'(Overflow), 0);
    pulses   = 0;
    clr_seen = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (L1_Trig_Out) pulses++;
      if (ClearTrigId) clr_seen++;
    end
    check("clr_no_more_pulses", pulses, 0);
    check("clr_one_cycle_only", clr_seen, 0);

    // LV1 in the cycle right after ClearIn starts a normal burst.
    TrigCnt = 4'd3;
    ClearIn = 1'b1;
    tick();
    ClearIn = 1'b0;
    Lv1_In  = 1'b1;
    check("clr_next_clrid", int'(ClearTrigId), 1);
    check("clr_next_l1_quiet", int'(L1_Trig_Out), 0);
    tick();
    Lv1_In = 1'b0;
    check("clr_next_clrid_off", int'(ClearTrigId), 0);
    check("clr_next_first_pulse", int'(L1_Trig_Out), 1);
    pulses = int'(L1_Trig_Out);
    for (int c = 0; c < 6; c++) begin
      tick();
      if (L1_Trig_Out) pulses++;
    end
    check("clr_next_pulses", pulses, 3);

    // Asynchronous reset in the middle of a burst with a non-empty queue.
    TrigCnt = 4'd8;
    for (int c = 0; c < 3; c++) begin
      Lv1_In = 1'b1;
      tick();
    end
    Lv1_In = 1'b0;
    check("arst_pre_pending", int'(Pending), 2);
    check("arst_pre_busy", int'(Busy), 1);
    #1 Reset = 1'b0;
    #1;
    check("arst_l1", int'(L1_Trig_Out), 0);
    check("arst_busy", int'(Busy), 0);
    check("arst_pending", int'(Pending), 0);
    check("arst_clrid", int'(ClearTrigId), 0);
    @(negedge Clk);
    Reset    = 1'b1;
    pulses   = 0;
    clr_seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (L1_Trig_Out) pulses++;
      if (ClearTrigId) clr_seen++;
    end
    check("arst_burst_lost", pulses, 0);
    check("arst_no_clrid", clr_seen, 0);

    // Corrupt one TMR copy during a burst.
    TrigCnt = 4'd6;
    check("tmr_err_idle", int'(Error), 0);
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      Lv1_In = (c == 0);
      if (c == 2) force dut.tmr0_q = ~dut.tmr1_q;
      tick();
      if (L1_Trig_Out) pulses++;
      if (c == 2) begin
        check("tmr_err_set", int'(Error), 1);
        release dut.tmr0_q;
      end
      if (c == 5) check("tmr_err_clear", int'(Error), 0);
    end
    Lv1_In = 1'b0;
    check("tmr_pulses", pulses, 6);
    check("tmr_final_busy", int'(Busy), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/l1_trig_multiplier.md
Name: l1_trig_multiplier

Overview:
- Upstream stage of the L1 trigger-ID counter.
- Converts single-cycle LV1 command pulses from the command decoder into bursts of TrigCnt consecutive L1 trigger pulses. These drive the counter's L1_Trig_In.
- Queues LV1 commands that arrive during a burst, forwards an event-counter clear as a one-cycle ClearTrigId, and reports drops.
- All state registers are triplicated with majority voting and mismatch detection, matching the SEU-hardening of the trigger path.

Parameters:
- CNT_W, 4, width of TrigCnt; value 0 means 2**CNT_W pulses.
- PEND_MAX, 4, maximum queued LV1 requests (1..15).
- DROP_W, 8, width of saturating drop counter.

Ports:
- Clk  input  1  system clock (40 MHz BC clock); all logic on posedge.
- Reset  input  1  asynchronous, active-low.
- Lv1_In  input  1  one-cycle LV1 command pulse.
- ClearIn  input  1  one-cycle event-counter-reset command.
- TrigCnt  input  CNT_W  pulses per LV1 (config register).
- L1_Trig_Out  output  1  trigger pulse to the trigger-ID counter (sampled there on negedge).
- ClearTrigId  output  1  one-cycle clear to the trigger-ID counter.
- Busy  output  1  burst in progress.
- Pending  output  4  queued LV1 count (majority value).
- Overflow  output  1  sticky: an LV1 was dropped.
- DropCnt  output  DROP_W  dropped LV1 count, saturating.
- Error  output  1  triplicated-register mismatch flag.

Behaviour:
- Reset values:
  - L1_Trig_Out=0, ClearTrigId=0, Busy=0, Pending=0, Overflow=0, DropCnt=0, Error=0.
  - Internal remain=0, latched count=0.
- All outputs are registered; none is combinational from inputs.
- States: IDLE (Busy=0) and BURST (Busy=1). Internal remain counter is CNT_W+1 bits.
- Define req = Lv1_In OR (Pending>0).
- IDLE with req in cycle N:
  - Latch TrigCnt (0 maps to 2**CNT_W) into remain; go to BURST.
  - L1_Trig_Out=1 in cycles N+1 through N+count.
  - First pulse latency is exactly 1 clock.
- BURST: each clock, L1_Trig_Out=1 and remain decrements.
  - When remain==1 and req: reload remain from TrigCnt sampled that cycle and stay in BURST. Next burst follows with no gap cycle.
  - When remain==1 and no req: go to IDLE; L1_Trig_Out=0 next cycle.
- Pending update: Pending_next = Pending + accept − consume.
  - consume = 1 when a burst starts or reloads from the queue.
  - If Lv1_In itself starts the burst and Pending==0, there is no queue change.
  - If Lv1_In arrives while the queue is being consumed, the net change is 0.
- Drop: Lv1_In is dropped when it arrives while Pending==PEND_MAX and no consume occurs that cycle.
  - Overflow sets (sticky until Reset or ClearIn).
  - DropCnt increments, saturating at all-ones.
- TrigCnt changes mid-burst do not affect the running burst; it is re-sampled only at start or reload.
- ClearIn (highest priority):
  - Next cycle: ClearTrigId=1 for exactly 1 cycle; Busy=0; L1_Trig_Out=0; Pending=0; remain=0; Overflow=0; DropCnt=0.
  - Lv1_In in the same cycle as ClearIn is discarded and not counted as a drop.
  - Lv1_In in the cycle after ClearIn is processed normally; the first pulse lands after ClearTrigId.
- TMR:
  - remain, Pending, state, Overflow and DropCnt each exist in 3 copies. Every copy loads the next value computed from the voted values.
  - Outputs are bitwise 2-of-3 majority.
  - Each posedge, if any copies disagree, three error flags are set. Error is the majority of these flags, i.e. 1 cycle after the mismatch. It self-clears once the copies agree, which they do after one clock through voting.
- Reset asserted mid-burst: immediate asynchronous return to reset values; the burst is lost and no ClearTrigId is issued.

Test Plan:
- Reset, TrigCnt=3, one Lv1_In at cycle 10 → L1_Trig_Out=1 in cycles 11–13, Busy 11–13, Pending stays 0.
- TrigCnt=0 → 16 consecutive pulses per LV1; TrigCnt=1 with Lv1_In every cycle for 5 cycles → 5 contiguous pulses, Pending stays 0.
- TrigCnt=4, Lv1_In at cycles 10, 11, 12 → 12 contiguous pulses (cycles 11–22), Pending peaks at 2, then returns to 0.
- TrigCnt=8, PEND_MAX=4, 6 extra Lv1_In pulses during the first burst → Pending=4, DropCnt=2, Overflow=1, 40 pulses total.
- ClearIn mid-burst with Pending=2 plus simultaneous Lv1_In → next cycle ClearTrigId=1 (1 cycle), L1_Trig_Out=0, Pending=0, DropCnt=0, no further pulses.
- Force one copy of remain to a wrong value → Error=1 one cycle later; L1_Trig_Out pulse count unchanged; Error returns to 0 after the copies resync.
